// File: rtl/mpx_stereo_decoder_if.sv
// rtl/mpx_stereo_decoder_if.sv - MPX decoder control/sample/audio bundle
// master drives run and the MPX samples; slave is the decoder.
interface mpx_stereo_decoder_if #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
);
  logic                    run;
  logic                    stb_in;
  logic signed [IN_W-1:0]  mpx_in;
  logic signed [OUT_W-1:0] left;
  logic signed [OUT_W-1:0] right;
  logic                    out_valid;
  logic                    locked;
  logic [1:0]              state;

  modport master (
    output run, stb_in, mpx_in,
    input  left, right, out_valid, locked, state
  );

  modport slave (
    input  run, stb_in, mpx_in,
    output left, right, out_valid, locked, state
  );
endinterface

// File: rtl/mpx_stereo_decoder.sv
// rtl/mpx_stereo_decoder.sv - FM stereo MPX decoder: pilot PLL, L-R demodulation, boxcar decimation, L/R matrix
// Optional: define DEEMPH_EN for first-order de-emphasis on the left/right outputs.
module mpx_stereo_decoder #(
  parameter int          IN_W       = 18,
  parameter int          OUT_W      = 16,
  parameter logic [23:0] FREQ_NOM   = 24'd66410,
  parameter int          FREQ_RANGE = 700,
  parameter int          PD_LOG2    = 6,
  parameter int          KP_SHIFT   = 8,
  parameter int          KI_SHIFT   = 14,
  parameter int          LOG2_DECIM = 7,
  parameter int          LOG2_LOCK  = 12,
  parameter int          LOCK_TH    = 1500
) (
  input logic                 clk,
  input logic                 rst,
  mpx_stereo_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam int I_MAX = FREQ_RANGE * (2 ** KI_SHIFT);
  localparam int O_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int O_MIN = -(2 ** (OUT_W - 1));

  state_t                  state_q;
  logic [23:0]             phase;
  logic [23:0]             freq;
  logic [PD_LOG2-1:0]      pd_cnt;
  logic [LOG2_LOCK-1:0]    lock_cnt;
  logic [LOG2_DECIM-1:0]   dec_cnt;
  logic signed [31:0]      pd_acc, integ, lock_acc, sacc, dacc;
  logic                    good_win;
  logic                    out_valid_q;
  logic                    locked_q;
  logic signed [OUT_W-1:0] left_q, right_q;

  logic signed [31:0]      mpx_w, pd_next, pd, i_sum, i_next, f_off;
  logic signed [31:0]      lock_next, lock_avg, sacc_next, dacc_next;
  logic signed [31:0]      sum, d, diff, l_full, r_full;
  logic [23:0]             freq_next;
  logic [1:0]              q_hi;
  logic                    s38_neg;
  logic signed [OUT_W-1:0] l_x, r_x, l_out, r_out;
`ifdef DEEMPH_EN
  logic signed [31:0]      l_dx, r_dx;
`endif

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [31:0] x);
    if (x > O_MAX)      return OUT_W'(O_MAX);
    else if (x < O_MIN) return OUT_W'(O_MIN);
    else                return x[OUT_W-1:0];
  endfunction

  always_comb begin
    mpx_w   = {{(32-IN_W){bus.mpx_in[IN_W-1]}}, bus.mpx_in};
    pd_next = pd_acc + (phase[23] ? -mpx_w : mpx_w);
    pd      = pd_next >>> PD_LOG2;
    i_sum   = integ + pd;
    if (i_sum > I_MAX)       i_next = I_MAX;
    else if (i_sum < -I_MAX) i_next = -I_MAX;
    else                     i_next = i_sum;
    f_off = (pd >>> KP_SHIFT) + (i_next >>> KI_SHIFT);
    if (f_off > FREQ_RANGE)       f_off = FREQ_RANGE;
    else if (f_off < -FREQ_RANGE) f_off = -FREQ_RANGE;
    freq_next = 24'($signed({8'd0, FREQ_NOM}) - f_off);

    lock_next = lock_acc + ((phase[23] ^ phase[22]) ? -mpx_w : mpx_w);
    lock_avg  = lock_next >>> LOG2_LOCK;

    // top two bits of (2p - quarter turn): only p[22:21] reach them
    q_hi    = phase[22:21] - 2'd1;
    s38_neg = q_hi[1] ^ q_hi[0];

    sacc_next = sacc + mpx_w;
    dacc_next = (state_q == LOCKED) ? dacc + (s38_neg ? -mpx_w : mpx_w) : 32'sd0;

    sum    = sacc_next >>> LOG2_DECIM;
    d      = dacc_next >>> LOG2_DECIM;
    diff   = d + (d >>> 1) + (d >>> 4) + (d >>> 7);
    l_full = (sum + diff) >>> 1;
    r_full = (sum - diff) >>> 1;
    l_x    = sat(l_full);
    r_x    = sat(r_full);
`ifdef DEEMPH_EN
    l_dx  = (32'(l_x) - 32'(left_q)) >>> 3;
    r_dx  = (32'(r_x) - 32'(right_q)) >>> 3;
    l_out = left_q + OUT_W'(l_dx);
    r_out = right_q + OUT_W'(r_dx);
`else
    l_out = l_x;
    r_out = r_x;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;     phase  <= '0;       freq     <= FREQ_NOM;
      pd_cnt   <= '0;       lock_cnt <= '0;     dec_cnt  <= '0;
      pd_acc   <= '0;       integ  <= '0;       lock_acc <= '0;
      sacc     <= '0;       dacc   <= '0;       good_win <= 1'b0;
      out_valid_q <= 1'b0;  locked_q <= 1'b0;   left_q <= '0;  right_q <= '0;
    end else if (!bus.run) begin
      state_q  <= IDLE;     phase  <= '0;       freq     <= FREQ_NOM;
      pd_cnt   <= '0;       lock_cnt <= '0;     dec_cnt  <= '0;
      pd_acc   <= '0;       integ  <= '0;       lock_acc <= '0;
      sacc     <= '0;       dacc   <= '0;       good_win <= 1'b0;
      out_valid_q <= 1'b0;  locked_q <= 1'b0;   left_q <= '0;  right_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == IDLE) state_q <= ACQUIRE;
      if (bus.stb_in) begin
        phase  <= phase + freq;
        pd_cnt <= pd_cnt + PD_LOG2'(1);
        if (&pd_cnt) begin
          pd_acc <= '0;
          integ  <= i_next;
          freq   <= freq_next;
        end else begin
          pd_acc <= pd_next;
        end

        // lock decisions use the state as it stood for the whole window
        lock_cnt <= lock_cnt + LOG2_LOCK'(1);
        if (&lock_cnt) begin
          lock_acc <= '0;
          if (state_q == LOCKED) begin
            if (lock_avg < LOCK_TH / 2) begin
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
              good_win <= 1'b0;
            end
          end else if (lock_avg > LOCK_TH) begin
            if (good_win) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              good_win <= 1'b0;
            end else begin
              good_win <= 1'b1;
            end
          end else begin
            good_win <= 1'b0;
          end
        end else begin
          lock_acc <= lock_next;
        end

        dec_cnt <= dec_cnt + LOG2_DECIM'(1);
        if (&dec_cnt) begin
          sacc        <= '0;
          dacc        <= '0;
          out_valid_q <= 1'b1;
          left_q      <= l_out;
          right_q     <= r_out;
        end else begin
          sacc <= sacc_next;
          dacc <= dacc_next;
        end
      end
    end
  end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.out_valid = out_valid_q;
  assign bus.locked    = locked_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_mpx_stereo_decoder.sv
// tb/tb_mpx_stereo_decoder.sv - directed self-checking bench for mpx_stereo_decoder
`timescale 1ns/1ps
module tb_mpx_stereo_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mpx_stereo_decoder_if #(.IN_W(18), .OUT_W(16)) bus ();
  mpx_stereo_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit [23:0] th;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    bus.run    = 1'b0;
    bus.stb_in = 1'b0;
    tick();
    bus.run = 1'b1;
  endtask

  task automatic dc_window(input int v, output int lat);
    lat = -1;
    bus.stb_in = 1'b1;
    bus.mpx_in = 18'(v);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic int mpx_of(input bit [23:0] ph, input real ap, input real ast, input int dc);
    real a;
    a = 6.283185307179586 * real'(ph) / 16777216.0;
    return int'(ap * $cos(a) + ast * $sin(2.0 * a)) + dc;
  endfunction

  task automatic step(input real ap, input real ast, input int dc);
    tick();
    th = th + 24'd66410;
    bus.mpx_in = 18'(mpx_of(th, ap, ast, dc));
  endtask

  task automatic wait_valid(input real ap, input real ast, input int dc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(ap, ast, dc);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, nv, sum_l, sum_r, n_tmo;
    bit ok;
    bus.run = 1'b0; bus.stb_in = 1'b0; bus.mpx_in = '0;
    #3 rst = 1'b0;
    #1;
    check("rst_left", int'(bus.left), 0);
    check("rst_state", int'(bus.state), 0);
    check("rst_locked", int'(bus.locked), 0);
    tick(); tick();
    rst = 1'b1;

    // mono DC, no pilot
    restart();
    check("idle_state", int'(bus.state), 0);
    dc_window(2000, lat);
    check("mono_latency", lat, 128);
    check("mono_state", int'(bus.state), 1);
    check("mono_left", int'(bus.left), 1000);
    check("mono_right", int'(bus.right), 1000);
    bus.stb_in = 1'b0;
    tick();
    check("mono_pulse_width", int'(bus.out_valid), 0);
    check("mono_hold", int'(bus.left), 1000);

    // asynchronous reset mid-run
    bus.stb_in = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_left", int'(bus.left), 0);
    check("arst_right", int'(bus.right), 0);
    check("arst_state", int'(bus.state), 0);
    check("arst_locked", int'(bus.locked), 0);
    tick();
    rst = 1'b1;

    // saturation and rounding toward -inf
    restart();
    dc_window(131071, lat);
    check("satp_left", int'(bus.left), 32767);
    check("satp_right", int'(bus.right), 32767);
    restart();
    dc_window(-131072, lat);
    check("satn_left", int'(bus.left), -32768);
    check("satn_right", int'(bus.right), -32768);
    restart();
    dc_window(-3, lat);
    check("neg_small_left", int'(bus.left), -2);

    // run dropped mid-window, strobes ignored while low
    restart();
    bus.stb_in = 1'b1;
    bus.mpx_in = 18'(2000);
    for (int i = 0; i < 50; i++) tick();
    bus.run = 1'b0;
    tick();
    check("runlow_state", int'(bus.state), 0);
    nv = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    check("runlow_no_valid", nv, 0);
    check("runlow_left", int'(bus.left), 0);
    bus.run = 1'b1;
    dc_window(400, lat);
    check("rerun_latency", lat, 128);
    check("rerun_left", int'(bus.left), 200);

    // pilot acquisition
    restart();
    th = '0;
    bus.stb_in = 1'b1;
    bus.mpx_in = 18'(mpx_of(th, 6553.0, 0.0, 0));
    n = 0;
    while (!bus.locked && n < 16384) begin
      step(6553.0, 0.0, 0);
      n++;
    end
    check("lock_reached", int'(bus.locked), 1);
    check_rng("lock_samples", n, 8192, 16384);
    check("lock_state", int'(bus.state), 2);

    // stereo separation: L=8000, R=-8000
    n_tmo = 0;
    sum_l = 0;
    sum_r = 0;
    for (int k = 0; k < 2; k++) begin
      wait_valid(6553.0, 16000.0, 0, ok);
      if (!ok) n_tmo++;
    end
    for (int k = 0; k < 64; k++) begin
      wait_valid(6553.0, 16000.0, 0, ok);
      if (!ok) n_tmo++;
      sum_l += int'(bus.left);
      sum_r += int'(bus.right);
    end
    check("stereo_timeouts", n_tmo, 0);
    check_rng("stereo_left_mean", sum_l / 64, 7840, 8160);
    check_rng("stereo_right_mean", sum_r / 64, -8160, -7840);
    check("stereo_locked", int'(bus.locked), 1);

    // pilot loss falls back to mono
    n = 0;
    while (bus.locked && n <= 8192) begin
      step(0.0, 0.0, 2000);
      n++;
    end
    check_rng("unlock_samples", n, 1, 8192);
    check("unlock_state", int'(bus.state), 1);
    wait_valid(0.0, 0.0, 2000, ok);
    wait_valid(0.0, 0.0, 2000, ok);
    check("unlock_valid", int'(ok), 1);
    check("unlock_left", int'(bus.left), 1000);
    check("unlock_right", int'(bus.right), 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
